// File: rtl/bin_to_bcd_3b_if.sv
// Request/result bundle between a conversion requester and bin_to_bcd_3b.
interface bin_to_bcd_3b_if;
  logic        start;
  logic [9:0]  bin;
  logic [11:0] number_BCD;
  logic        busy;
  logic        done;
  logic        overflow;

  // Requester drives the operand and start, observes the result.
  modport master (
    output start, bin,
    input  number_BCD, busy, done, overflow
  );

  // Converter samples the operand and start, drives the result.
  modport slave (
    input  start, bin,
    output number_BCD, busy, done, overflow
  );
endinterface

// File: rtl/bin_to_bcd_3b.sv
// Sequential 10-bit binary to 3-digit BCD converter (shift-and-add-3).
// One operand accepted in IDLE, ten shift cycles, result registered at the
// last shift together with a one-cycle done pulse.
module bin_to_bcd_3b #(
  parameter bit SATURATE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  bin_to_bcd_3b_if.slave  bus
);

  localparam int unsigned BIN_W = 10;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned SCR_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_IN_RANGE = BIN_W'(999);
  localparam logic [BCD_W-1:0] SAT_VALUE = 12'h999;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [SCR_W-1:0]   scr_q, scr_d, scr_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  function automatic logic [3:0] dabble(input logic [3:0] d);
    return (d >= 4'd5) ? 4'(d + 4'd3) : d;
  endfunction

  // Add-3 correction on every scratch digit ahead of the shift.
  assign scr_adj = {dabble(scr_q[15:12]), dabble(scr_q[11:8]),
                    dabble(scr_q[7:4]),   dabble(scr_q[3:0])};

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = bus.bin;
          scr_d   = '0;
          cnt_d   = '0;
          ovf_d   = (bus.bin > MAX_IN_RANGE);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = {scr_adj[SCR_W-2:0], sr_q[BIN_W-1]};
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
        cnt_d = CNT_W'(cnt_q + 4'd1);
        if (cnt_q == LAST_SHIFT) begin
          // Thousands digit is dropped; saturation replaces the whole value.
          bcd_d   = (SATURATE && ovf_q) ? SAT_VALUE : scr_d[BCD_W-1:0];
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.number_BCD = bcd_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_3b.sv
// Testbench for bin_to_bcd_3b: saturating and wrapping instances driven in
// lockstep, results compared against a decimal arithmetic model.
module tb_bin_to_bcd_3b;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  bin_to_bcd_3b_if if_s ();
  bin_to_bcd_3b_if if_w ();

  bin_to_bcd_3b #(.SATURATE(1'b1)) u_sat  (.clk(clk), .rst(rst), .bus(if_s.slave));
  bin_to_bcd_3b #(.SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(if_w.slave));

  always #5 clk = ~clk;

  // Decimal reference: clamp or wrap above 999, then split into digits.
  function automatic logic [11:0] ref_bcd(input int v, input bit sat);
    int r;
    r = (v > 999) ? (sat ? 999 : v % 1000) : v;
    return 12'(((r / 100) << 8) | (((r / 10) % 10) << 4) | (r % 10));
  endfunction

  function automatic bit digits_ok(input logic [11:0] x);
    return (x[11:8] <= 4'd9) && (x[7:4] <= 4'd9) && (x[3:0] <= 4'd9);
  endfunction

  task automatic drive(input logic s, input logic [9:0] b);
    if_s.start = s; if_s.bin = b;
    if_w.start = s; if_w.bin = b;
  endtask

  // Full conversion with latency, hold, result, overflow and digit checks.
  task automatic convert(input int b, input string tag);
    logic [11:0] prev_s, prev_w;
    int n;
    @(negedge clk);
    prev_s = if_s.number_BCD;
    prev_w = if_w.number_BCD;
    drive(1'b1, 10'(b));
    @(negedge clk);
    drive(1'b0, 10'($urandom_range(0, 1023)));
    checks++;
    if (if_s.busy !== 1'b1 || if_w.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_accept: got %b/%b want 1", tag, if_s.busy, if_w.busy);
    end
    n = 0;
    while (if_s.done !== 1'b1 && n < 20) begin
      if (if_s.number_BCD !== prev_s || if_w.number_BCD !== prev_w) begin
        checks++; failures++;
        $display("FAIL %s hold_during_shift: got %h/%h want %h/%h", tag,
                 if_s.number_BCD, if_w.number_BCD, prev_s, prev_w);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 10 || if_w.done !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: got %0d edges (wrap done=%b) want 10", tag, n, if_w.done);
    end
    checks++;
    if (if_s.number_BCD !== ref_bcd(b, 1'b1) || if_w.number_BCD !== ref_bcd(b, 1'b0)) begin
      failures++;
      $display("FAIL %s result bin=%0d: got %h/%h want %h/%h", tag, b, if_s.number_BCD,
               if_w.number_BCD, ref_bcd(b, 1'b1), ref_bcd(b, 1'b0));
    end
    checks++;
    if (!digits_ok(if_s.number_BCD) || !digits_ok(if_w.number_BCD)) begin
      failures++;
      $display("FAIL %s digit_range: got %h/%h want all nibbles <= 9", tag,
               if_s.number_BCD, if_w.number_BCD);
    end
    checks++;
    if (if_s.overflow !== (b > 999) || if_w.overflow !== (b > 999) || if_s.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s overflow_busy bin=%0d: got ovf %b/%b busy %b want ovf %b busy 0",
               tag, b, if_s.overflow, if_w.overflow, if_s.busy, b > 999);
    end
    @(negedge clk);
    checks++;
    if (if_s.done !== 1'b0 || if_w.done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_one_cycle: got %b/%b want 0", tag, if_s.done, if_w.done);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (if_s.number_BCD !== 12'h000 || if_s.busy !== 1'b0 || if_s.done !== 1'b0 ||
        if_s.overflow !== 1'b0 || if_w.number_BCD !== 12'h000 || if_w.busy !== 1'b0 ||
        if_w.done !== 1'b0 || if_w.overflow !== 1'b0) begin
      failures++;
      $display("FAIL %s: got bcd %h/%h busy %b/%b done %b/%b ovf %b/%b want all zero", tag,
               if_s.number_BCD, if_w.number_BCD, if_s.busy, if_w.busy,
               if_s.done, if_w.done, if_s.overflow, if_w.overflow);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 10'd0);
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    repeat (2) @(negedge clk);
    check_zero("reset_held");
    rst = 1'b0;
  endtask

  task automatic test_zero();
    convert(0, "zero");
  endtask

  task automatic test_directed();
    convert(999, "d999");
    convert(255, "d255");
    convert(100, "d100");
    convert(1023, "d1023");
    convert(5, "d5_after_ovf");
  endtask

  // start and bin changes while shifting must not queue or disturb anything.
  task automatic test_start_ignored();
    int n, dones;
    @(negedge clk);
    drive(1'b1, 10'd42);
    @(negedge clk);
    drive(1'b0, 10'd42);
    repeat (3) @(negedge clk);
    drive(1'b1, 10'd7);
    @(negedge clk);
    drive(1'b0, 10'd7);
    dones = 0;
    for (n = 0; n < 25; n++) begin
      if (if_s.done === 1'b1) begin
        dones++;
        checks++;
        if (if_s.number_BCD !== 12'h042 || if_w.number_BCD !== 12'h042) begin
          failures++;
          $display("FAIL ignore_start result: got %h/%h want 042", if_s.number_BCD, if_w.number_BCD);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL ignore_start done_count: got %0d want 1", dones);
    end
  endtask

  // Reset mid-conversion discards the partial result and suppresses done.
  task automatic test_reset_abort();
    int dones;
    @(negedge clk);
    drive(1'b1, 10'd500);
    @(negedge clk);
    drive(1'b0, 10'd500);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("abort_immediate");
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (if_s.done === 1'b1 || if_w.done === 1'b1 || if_s.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", dones);
    end
    check_zero("abort_after");
    convert(500, "after_abort");
  endtask

  // start held high: one result every 11 edges.
  task automatic test_back_to_back();
    int t, last, seen;
    @(negedge clk);
    drive(1'b1, 10'd123);
    last = -1;
    seen = 0;
    for (t = 0; t < 60 && seen < 4; t++) begin
      @(negedge clk);
      if (if_s.done === 1'b1) begin
        checks++;
        if (if_s.number_BCD !== 12'h123 || if_w.number_BCD !== 12'h123) begin
          failures++;
          $display("FAIL b2b result: got %h/%h want 123", if_s.number_BCD, if_w.number_BCD);
        end
        if (last >= 0) begin
          checks++;
          if (t - last != 11) begin
            failures++;
            $display("FAIL b2b period: got %0d want 11", t - last);
          end
        end
        last = t;
        seen++;
        if (seen == 4) drive(1'b0, 10'd0);
      end
    end
    checks++;
    if (seen != 4) begin
      failures++;
      $display("FAIL b2b pulse_count: got %0d want 4", seen);
    end
    t = 0;
    while (if_s.busy === 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 1024; v++) convert(v, "sweep");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) convert(int'($urandom_range(0, 1023)), "random");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
